// File: rtl/cnt5_pkg.sv
// cnt5_pkg: shared state encodings and counter constants for the mod-5 arbiter
package cnt5_pkg;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [2:0] ZERO  = 3'b000;
   localparam logic [2:0] ONE   = 3'b001;
   localparam logic [2:0] TWO   = 3'b010;
   localparam logic [2:0] THREE = 3'b011;
   localparam logic [2:0] FOUR  = 3'b100;
   localparam int CNT_MOD = 5;
endpackage

// File: rtl/cnt5_arb_if.sv
// cnt5_arb_if: requester-side job handshake and counter observation bundle
interface cnt5_arb_if #(parameter int STEP_W = 3);
   logic [1:0] req;
   logic dir0;
   logic dir1;
   logic [STEP_W-1:0] steps0;
   logic [STEP_W-1:0] steps1;
   logic [1:0] gnt;
   logic [1:0] done;
   logic busy;
   logic [2:0] cnt;
   modport master (output req, dir0, dir1, steps0, steps1, input gnt, done, busy, cnt);
   modport slave (input req, dir0, dir1, steps0, steps1, output gnt, done, busy, cnt);
endinterface

// File: rtl/cnt5_en.sv
// cnt5_en: mod-5 up/down counter with enable, wrapping 4->0 and 0->4
module cnt5_en
   import cnt5_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic inc,
   output logic [2:0] cnt
);
   localparam logic [2:0] TOP = 3'(CNT_MOD - 1);
   // step once per enabled cycle in the requested direction, wrapping at the ends
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) cnt <= ZERO;
      else if (en) cnt <= inc ? ((cnt == TOP) ? ZERO : cnt + ONE) : ((cnt == ZERO) ? TOP : cnt - ONE);
endmodule

// File: rtl/cnt5_arb.sv
// cnt5_arb: two-requester round-robin job sequencer driving a shared mod-5 counter
module cnt5_arb
   import cnt5_pkg::*;
#(
   parameter int STEP_W = 3
) (
   input  logic clk,
   input  logic reset_n,
   cnt5_arb_if.slave bus
);
   logic [1:0] state;
   logic owner;
   logic dir;
   logic ptr;
   logic [STEP_W-1:0] rem;
   logic [1:0] gnt;
   logic [1:0] done;
   logic [2:0] cnt;
   logic win;
   logic [1:0] win_oh;
   logic [STEP_W-1:0] win_steps;
   logic [1:0] own_oh;
   assign win = (bus.req == 2'b11) ? ptr : bus.req[1];
   assign win_oh = win ? 2'b10 : 2'b01;
   assign win_steps = win ? bus.steps1 : bus.steps0;
   assign own_oh = owner ? 2'b10 : 2'b01;
   assign bus.gnt = gnt;
   assign bus.done = done;
   assign bus.busy = (state != IDLE);
   assign bus.cnt = cnt;
   cnt5_en u_cnt (
      .clk(clk),
      .reset_n(reset_n),
      .en(state == RUN),
      .inc(dir),
      .cnt(cnt)
   );
   // arbitrate in IDLE, count down the latched job in RUN, hand priority over after DONE
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state <= IDLE;
         owner <= 1'b0;
         dir <= 1'b0;
         ptr <= 1'b0;
         rem <= '0;
         gnt <= 2'b00;
         done <= 2'b00;
      end else begin
         gnt <= 2'b00;
         case (state)
            IDLE:
               if (|bus.req) begin
                  owner <= win;
                  dir <= win ? bus.dir1 : bus.dir0;
                  rem <= win_steps;
                  gnt <= win_oh;
                  state <= (win_steps == '0) ? DONE : RUN;
                  done <= (win_steps == '0) ? win_oh : 2'b00;
               end
            RUN: begin
               rem <= rem - 1'b1;
               if (rem == STEP_W'(1)) begin
                  state <= DONE;
                  done <= own_oh;
               end
            end
            DONE: begin
               done <= 2'b00;
               ptr <= ~owner;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule
